bpu_update_unit: RTL

Branch-resolution side of the branch predictor. It accepts resolved control-transfer results from the execute stage and compares each one with the prediction carried down the pipe. On a mispredict it issues a one-cycle fetch redirect. Taken branches whose target was missing or wrong are queued as BTB write requests and drained one per cycle into the BTB update port (`isBranch` / `update_addr` / `branch_addr`).

---
 rtl/bpu_pkg.sv | 18 +
 rtl/bpu_upd_fifo.sv | 56 +++++
 rtl/bpu_update_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch-predictor update path.
// Address width comes from the `ADDR_WIDTH macro so the queue entry type matches the BTB.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package bpu_pkg;

   localparam int BPU_ADDR_W = `ADDR_WIDTH;
   localparam int BPU_QDEPTH = 4;
   localparam int INSN_BYTES = 4;

   typedef struct packed {
      logic [BPU_ADDR_W-1:0] pc;
      logic [BPU_ADDR_W-1:0] target;
   } bpu_upd_t;

endpackage

// File: rtl/bpu_upd_fifo.sv
// Circular FIFO of BTB write requests with an in-place tail-target overwrite port.
// Head entry and tail pc are read combinationally from the storage array.
module bpu_upd_fifo
   import bpu_pkg::*;
#(
   parameter int DEPTH = BPU_QDEPTH,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  ovr,
   input  logic                  pop,
   input  bpu_upd_t              wr,
   output logic [CW-1:0]         count,
   output bpu_upd_t              head,
   output logic [BPU_ADDR_W-1:0] tail_pc
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] head_ptr;
   logic [PW-1:0] tail_ptr;
   logic [PW-1:0] last_ptr;
   bpu_upd_t      mem [DEPTH];

   assign last_ptr = tail_ptr - 1'b1;
   assign head     = mem[head_ptr];
   assign tail_pc  = mem[last_ptr].pc;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (push) tail_ptr <= tail_ptr + 1'b1;
         if (pop)  head_ptr <= head_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; validity is tracked by count, so stale data is never observed.
   always_ff @(posedge clk) begin
      if (push)
         mem[tail_ptr] <= wr;
      else if (ovr)
         mem[last_ptr].target <= wr.target;
   end

endmodule

// File: rtl/bpu_update_unit.sv
// Branch-resolution unit: detects mispredicts, pulses a fetch redirect and
// queues BTB corrections that drain one per cycle into the BTB update port.
module bpu_update_unit
   import bpu_pkg::*;
#(
   parameter int ADDR_WIDTH = `ADDR_WIDTH,
   parameter int QDEPTH     = BPU_QDEPTH,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic [ADDR_WIDTH-1:0] ex_pc,
   input  logic                  ex_taken,
   input  logic [ADDR_WIDTH-1:0] ex_target,
   input  logic                  ex_pred_taken,
   input  logic [ADDR_WIDTH-1:0] ex_pred_addr,
   output logic                  redirect_valid,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  upd_valid,
   output logic [ADDR_WIDTH-1:0] upd_pc,
   output logic [ADDR_WIDTH-1:0] upd_target,
   output logic [CNT_WIDTH-1:0]  mispred_cnt
);

   localparam int CW = $clog2(QDEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(QDEPTH);

   logic          mispred;
   logic          need_upd;
   logic          accept;
   logic          coalesce;
   logic          push;
   logic          ovr;
   logic [CW-1:0] count;
   bpu_upd_t      wr;
   bpu_upd_t      head;
   logic [ADDR_WIDTH-1:0] tail_pc;

   assign mispred  = (ex_taken != ex_pred_taken) ||
                     (ex_taken && ex_pred_taken && (ex_target != ex_pred_addr));
   assign need_upd = ex_taken && (!ex_pred_taken || (ex_target != ex_pred_addr));
   assign ex_ready = (count < FULL);
   assign accept   = ex_valid && ex_ready;
   assign upd_valid = (count != '0);

   // With a single entry the tail is also the head popping this cycle, so merge only above one.
   assign coalesce = (|count[CW-1:1]) && (tail_pc == ex_pc);

   assign wr         = '{pc: ex_pc, target: ex_target};
   assign upd_pc     = head.pc;
   assign upd_target = head.target;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      push = 1'b0;
      ovr  = 1'b0;
      if (accept && need_upd) begin
         if (coalesce) ovr  = 1'b1;
         else          push = 1'b1;
      end
   end

   bpu_upd_fifo #(
      .DEPTH (QDEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .ovr     (ovr),
      .pop     (upd_valid),
      .wr      (wr),
      .count   (count),
      .head    (head),
      .tail_pc (tail_pc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         mispred_cnt    <= '0;
      end else begin
         redirect_valid <= accept && mispred;
         if (accept && mispred) begin
            redirect_pc <= ex_taken ? ex_target : ex_pc + ADDR_WIDTH'(INSN_BYTES);
            if (mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
         end
      end
   end

endmodule
